// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the fetch path
//
// Purpose: fetch-state encoding, default PC type and the instruction value
// presented while the prefetch stream is empty.
package cu_pkg;

  localparam int CU_ADDRESS_WIDTH = 5;

  typedef logic [CU_ADDRESS_WIDTH:0] pc_t;

  // FETCH issues requests; DROP waits out one stale outstanding request.
  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO with flush for prefetched words
//
// Purpose: holds {instruction, pc} entries between memory return and decode.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   flush_i           empty the FIFO (wins over a same-cycle push/pop)
//   push_i/push_data_i  write an entry
//   pop_i             remove the head (ignored when empty)
//   head_valid_o/head_data_o  current head
//   count_o           number of stored entries, log2(DEPTH)+1 bits
module prefetch_fifo
  import cu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch stage feeding decode
//
// Purpose: keeps one request outstanding to instruction memory, buffers the
// returned words and streams them to decode tagged with their PC; a redirect
// flushes everything and restarts fetch at a new PC.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   imem_req/imem_addr          registered fetch request, held until acked
//   imem_ack/imem_rdata         memory return
//   redirect/redirect_pc        flush and restart fetch
//   out_valid/out_ready         head handshake to decode
//   out_instruction/out_pc      head contents (zero while empty)
module inst_prefetch
  import cu_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 5,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int DEPTH            = 4,
  parameter logic [ADDRESS_WIDTH:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [ADDRESS_WIDTH:0]      imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        redirect,
  input  logic [ADDRESS_WIDTH:0]      redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [ADDRESS_WIDTH:0]      out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTRUCTION_SIZE + ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] PC_ONE = 1;

  fetch_state_e           state_q;
  logic [ADDRESS_WIDTH:0] fetch_pc_q;
  logic [ADDRESS_WIDTH:0] addr_q;
  logic                   req_q;

  logic                   ack;
  logic                   push;
  logic                   pop;
  logic                   head_valid;
  logic [EW-1:0]          head_data;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic [ADDRESS_WIDTH:0] pc_next;

  assign ack        = imem_ack && req_q;
  // Data returned for a stale request (DROP) or in a redirect cycle is discarded.
  assign push       = ack && (state_q == FETCH) && !redirect;
  assign pop        = head_valid && out_ready && !redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  // fetch_pc tracks the in-flight address, so the next one is +1 on ack.
  assign pc_next    = ack ? fetch_pc_q + PC_ONE : fetch_pc_q;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .push_data_i  ({imem_rdata, addr_q}),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .count_o      (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      if (req_q && !imem_ack) begin
        // The in-flight request cannot be withdrawn; hold it and drop its data.
        state_q <= DROP;
      end else begin
        state_q <= FETCH;
        req_q   <= 1'b1;
        addr_q  <= redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q || imem_ack) begin
            fetch_pc_q <= pc_next;
            addr_q     <= pc_next;
            // Issue only if the FIFO can hold this word once it returns.
            req_q      <= (count_next < CW'(DEPTH));
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign out_valid       = head_valid;
  assign out_instruction = head_valid ? head_data[EW-1 -: INSTRUCTION_SIZE]
                                      : INSTRUCTION_SIZE'(INSTR_NOP);
  assign out_pc          = head_valid ? head_data[ADDRESS_WIDTH:0] : '0;

endmodule
